// File: rtl/stopwatch_control.sv
// Stopwatch front end: button synchronise/debounce, IDLE/RUN/PAUSED control and count timebase.
// Define STOPWATCH_LAP_EN to add the lap button and display_hold output.
module stopwatch_control #(
    parameter int unsigned TICK_CYCLES     = 1_000_000,
    parameter int unsigned TICK_WID        = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned DB_WID          = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic btn_lap,
    output logic display_hold,
`endif
    output logic increment,
    output logic counter_clear,
    output logic running
);

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned BTN_LAP   = 2;
    localparam int unsigned NBTN      = 3;
`else
    localparam int unsigned NBTN      = 2;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [NBTN-1:0]     btn_raw;
    logic [NBTN-1:0]     press_d;
    logic [NBTN-1:0]     press_q;
    logic [1:0]          state_q, state_d;
    logic [TICK_WID-1:0] tick_q, tick_d;
    logic                increment_q, increment_d;
    logic                clear_q, clear_d;
    logic                running_q;

`ifdef STOPWATCH_LAP_EN
    logic hold_q, hold_d;
    assign btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
    assign btn_raw = {btn_clear, btn_start_stop};
`endif

    // Per-button 2-flop synchroniser and debouncer; press is the rising edge of the stable level.
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        logic              sync1_q, sync2_q;
        logic              stable_q, stable_d;
        logic [DB_WID-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= btn_raw[g];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync2_q != stable_q) begin
                if (cnt_q == DB_WID'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + DB_WID'(1);
                end
            end
        end

        assign press_d[g] = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_q     <= '0;
            state_q     <= S_IDLE;
            tick_q      <= '0;
            increment_q <= 1'b0;
            clear_q     <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            press_q     <= press_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            increment_q <= increment_d;
            clear_q     <= clear_d;
            running_q   <= (state_d == S_RUN);
        end
    end

    // Control FSM and timebase; clear outranks start except in RUN where clear is ignored.
    always_comb begin
        state_d     = state_q;
        clear_d     = 1'b0;
        tick_d      = tick_q;
        increment_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (press_q[BTN_CLEAR]) begin
                    clear_d = 1'b1;
                end else if (press_q[BTN_START]) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (press_q[BTN_START]) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (press_q[BTN_CLEAR]) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                end else if (press_q[BTN_START]) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only cycles that stay in RUN advance the tick, so a wrap never lands outside RUN.
        if (state_q == S_IDLE || state_d == S_IDLE) begin
            tick_d = '0;
        end else if (state_q == S_RUN && state_d == S_RUN) begin
            if (tick_q == TICK_WID'(TICK_CYCLES - 1)) begin
                tick_d      = '0;
                increment_d = 1'b1;
            end else begin
                tick_d = tick_q + TICK_WID'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (state_d == S_IDLE) begin
            hold_d = 1'b0;
        end else if (press_q[BTN_LAP]) begin
            hold_d = (state_q == S_RUN) ? ~hold_q : 1'b0;
        end
    end

    assign display_hold = hold_q;
`endif

    assign increment     = increment_q;
    assign counter_clear = clear_q;
    assign running       = running_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed scenarios plus random button traffic against a cycle model.
// Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_control;

    localparam int TICK = 10;
    localparam int DB   = 4;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start_stop = 1'b0;
    logic btn_clear = 1'b0;
    logic btn_lap = 1'b0;
    logic increment, counter_clear, running;
`ifdef STOPWATCH_LAP_EN
    logic display_hold;
`endif

    int errors = 0;
    int checks = 0;
    int cc_seen = 0;
    int inc_seen = 0;

    // Reference model state
    int m_s1[3], m_s2[3], m_stable[3], m_cnt[3], m_press[3];
    int m_state = ST_IDLE;
    int m_phase = 0;
    bit m_inc = 0, m_clr = 0, m_run = 0, m_hold = 0;

    stopwatch_control #(
        .TICK_CYCLES(10), .TICK_WID(4), .DEBOUNCE_CYCLES(4), .DB_WID(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_start_stop(btn_start_stop),
        .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(btn_lap),
        .display_hold(display_hold),
`endif
        .increment(increment),
        .counter_clear(counter_clear),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the behavioural stopwatch, using the inputs present at the edge.
    task automatic model_edge();
        int b[3];
        int nst;
        bit clr_acc, inc;
        b[0] = int'(btn_start_stop);
        b[1] = int'(btn_clear);
        b[2] = int'(btn_lap);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_cnt[i] = 0; m_press[i] = 0;
            end
            m_state = ST_IDLE; m_phase = 0;
            m_inc = 0; m_clr = 0; m_run = 0; m_hold = 0;
            return;
        end
        nst = m_state; clr_acc = 0; inc = 0;
        if (m_state == ST_RUN) begin
            if (m_press[0] != 0) nst = ST_PAUSED;
        end else if (m_press[1] != 0) begin
            clr_acc = 1;
            nst = ST_IDLE;
        end else if (m_press[0] != 0) begin
            nst = ST_RUN;
        end
        if (m_state == ST_RUN && nst == ST_RUN) begin
            m_phase = m_phase + 1;
            if (m_phase == TICK) begin
                m_phase = 0;
                inc = 1;
            end
        end
        if (m_state == ST_IDLE || nst == ST_IDLE) m_phase = 0;
        if (nst == ST_IDLE) m_hold = 0;
        else if (m_press[2] != 0) m_hold = (m_state == ST_RUN) ? !m_hold : 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_press[i] = 0;
            if (m_s2[i] != m_stable[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == DB) begin
                    m_stable[i] = m_s2[i];
                    m_cnt[i] = 0;
                    m_press[i] = m_stable[i];
                end
            end else begin
                m_cnt[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = b[i];
        end
        m_state = nst;
        m_run = (nst == ST_RUN);
        m_inc = inc;
        m_clr = clr_acc;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("running", running, m_run);
        chk("increment", increment, m_inc);
        chk("counter_clear", counter_clear, m_clr);
`ifdef STOPWATCH_LAP_EN
        chk("display_hold", display_hold, m_hold);
`endif
        if (counter_clear === 1'b1) cc_seen++;
        if (increment === 1'b1) inc_seen++;
    endtask

    task automatic press(input bit s, input bit c, input bit l, input int len, input int gap);
        btn_start_stop = s; btn_clear = c; btn_lap = l;
        repeat (len) step();
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        repeat (gap) step();
    endtask

    // Hold start until running rises, then count RUN cycles until the next increment.
    task automatic start_and_time(output int lat, output int to_inc);
        btn_start_stop = 1'b1;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin step(); lat++; end
        btn_start_stop = 1'b0;
        to_inc = 0;
        while (increment !== 1'b1 && to_inc < 30) begin step(); to_inc++; end
    endtask

    initial begin
        int lat, n, r, len;
        bit s, c, l;

        repeat (3) step();
        chk("reset_running", running, 1'b0);
        chk("reset_clear", counter_clear, 1'b0);
        reset = 1'b0;
        step();

        // Short glitch must not register a press
        press(1, 0, 0, 3, 12);
        chk("glitch_idle", running, 1'b0);

        // Held start: one press, latency 2+4+1, first increment TICK after RUN entry
        btn_start_stop = 1'b1;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin step(); lat++; end
        chk_int("start_latency", lat, 7);
        n = 0;
        while (increment !== 1'b1 && n < 30) begin
            step(); n++;
            if (lat + n == 10) btn_start_stop = 1'b0;
        end
        chk_int("first_increment", n, TICK);
        btn_start_stop = 1'b0;
        inc_seen = 0;
        repeat (TICK * 3) step();
        chk_int("increment_rate", inc_seen, 3);
        chk("still_running", running, 1'b1);

        // Pause right after an increment: 6 counted cycles preserved, 4 remain after resume
        n = 0;
        while (increment !== 1'b1 && n < 30) begin step(); n++; end
        inc_seen = 0;
        press(1, 0, 0, 6, 50);
        chk_int("inc_while_paused", inc_seen, 0);
        chk("paused", running, 1'b0);
        start_and_time(lat, n);
        chk_int("resume_remaining", n, TICK - 6);

        // Clear ignored in RUN, honoured in PAUSED
        cc_seen = 0;
        press(0, 1, 0, 6, 12);
        chk_int("clear_in_run", cc_seen, 0);
        chk("clear_in_run_running", running, 1'b1);
        press(1, 0, 0, 6, 12);
        cc_seen = 0;
        press(0, 1, 0, 6, 12);
        chk_int("clear_in_paused", cc_seen, 1);
        chk("after_clear", running, 1'b0);
        start_and_time(lat, n);
        chk_int("after_clear_first_inc", n, TICK);

        // Simultaneous start+clear: clear wins in PAUSED, start acts in RUN
        press(1, 0, 0, 6, 12);
        cc_seen = 0;
        press(1, 1, 0, 6, 12);
        chk_int("both_in_paused_clear", cc_seen, 1);
        chk("both_in_paused_idle", running, 1'b0);
        press(1, 0, 0, 6, 12);
        cc_seen = 0;
        press(1, 1, 0, 6, 12);
        chk_int("both_in_run_clear", cc_seen, 0);
        chk("both_in_run_paused", running, 1'b0);

        // Reset mid-RUN
        press(1, 0, 0, 6, 15);
        reset = 1'b1;
        step();
        chk("midrst_running", running, 1'b0);
        chk("midrst_increment", increment, 1'b0);
        chk("midrst_clear", counter_clear, 1'b0);
        reset = 1'b0;
        repeat (2) step();

`ifdef STOPWATCH_LAP_EN
        press(1, 0, 0, 6, 12);
        inc_seen = 0;
        press(0, 0, 1, 6, 30);
        chk("lap1_hold", display_hold, 1'b1);
        chk("lap1_counting", inc_seen >= 2, 1'b1);
        press(0, 0, 1, 6, 12);
        chk("lap2_hold", display_hold, 1'b0);
        press(0, 0, 1, 6, 12);
        chk("lap3_hold", display_hold, 1'b1);
        press(1, 0, 0, 6, 12);
        press(0, 1, 0, 6, 12);
        chk("lap_cleared", display_hold, 1'b0);
`endif

        // Random button traffic
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                reset = 1'b1;
                repeat (int'($urandom_range(1, 2))) step();
                reset = 1'b0;
            end else begin
                s = (r % 3) != 0;
                c = (r % 5) == 0 || (r % 7) == 0;
                l = (r % 4) == 1;
                if (!s && !c && !l) s = 1'b1;
                len = int'($urandom_range(1, 9));
                press(s, c, l, len, int'($urandom_range(2, 25)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
